// File: rtl/el2_ifu_iccm_ecc_corr_pkg.sv
// Shared types and codeword layout for the ICCM ECC check/correct block.
// Data bits occupy the non-power-of-two Hamming positions 1..38; bit 38 is overall parity.
package el2_ifu_iccm_ecc_corr_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_LO = 2'd1,
      REQ_HI = 2'd2
   } iccm_corr_state_t;

   localparam logic [2:0] ICCM_CORR_WR_SIZE = 3'b010;
   localparam int         ICCM_ECC_WIDTH    = 7;
   localparam int         ICCM_CW_W         = 32 + ICCM_ECC_WIDTH;

   // Codeword bit index carrying data bit j.
   function automatic int data_bit_idx(input int j);
      int k;
      int idx;
      k   = 0;
      idx = 0;
      for (int p = 1; p <= ICCM_CW_W - 1; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (k == j) idx = p - 1;
            k++;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/el2_ifu_iccm_ecc_corr_secded_dec.sv
// SECDED decoder for one 39-bit ICCM codeword: syndrome, correction and data extraction.
module el2_ifu_iccm_secded_dec
   import el2_ifu_iccm_ecc_corr_pkg::*;
(
   input  logic [ICCM_CW_W-1:0] cw_i,
   output logic [ICCM_CW_W-1:0] cw_corr_o,
   output logic [31:0]          data_o,
   output logic                 sb_o,
   output logic                 db_o
);

   localparam int HAM_N = ICCM_CW_W - 1;

   logic [5:0] syn;
   logic       par;

   always_comb begin
      syn = '0;
      for (int i = 0; i < HAM_N; i++) begin
         if (cw_i[i]) syn = syn ^ 6'(i + 1);
      end
   end

   assign par = ^cw_i;

   // A syndrome beyond the last position cannot come from one flip, so it is uncorrectable.
   always_comb begin
      cw_corr_o = cw_i;
      for (int i = 0; i < HAM_N; i++) begin
         if (par && (syn == 6'(i + 1))) cw_corr_o[i] = ~cw_i[i];
      end
      if (par && (syn == '0)) cw_corr_o[HAM_N] = ~cw_i[HAM_N];
   end

   assign sb_o = par & (syn <= 6'(HAM_N));
   assign db_o = (par & (syn > 6'(HAM_N))) | (~par & (syn != '0));

   for (genvar j = 0; j < 32; j++) begin : g_ext
      assign data_o[j] = cw_corr_o[data_bit_idx(j)];
   end

endmodule

// File: rtl/el2_ifu_iccm_ecc_corr.sv
// ICCM read-path SECDED check/correct with single-bit write-back scheduling.
// Optional ICCM_ECC_ERR_CNT_EN adds saturating SB/DB error counters with cnt_clr.
module el2_ifu_iccm_ecc_corr
   import el2_ifu_iccm_ecc_corr_pkg::*;
#(
   parameter int ICCM_BITS = 16
`ifdef ICCM_ECC_ERR_CNT_EN
   ,
   parameter int ERR_CNT_W = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic                 rd_vld,
   input  logic [ICCM_BITS-1:1] rd_addr_q,
   input  logic [77:0]          iccm_rd_data_ecc,
   input  logic                 corr_gnt,
   output logic [63:0]          rd_data_corr,
   output logic [1:0]           sb_err,
   output logic [1:0]           db_err,
   output logic                 corr_req,
   output logic [ICCM_BITS-1:1] corr_wr_addr,
   output logic [77:0]          corr_wr_data,
   output logic [2:0]           corr_wr_size,
   output logic                 iccm_buf_correct_ecc,
   output logic                 iccm_correction_state
`ifdef ICCM_ECC_ERR_CNT_EN
   ,
   input  logic                 cnt_clr,
   output logic [ERR_CNT_W-1:0] sb_cnt,
   output logic [ERR_CNT_W-1:0] db_cnt
`endif
);

   localparam logic [ICCM_BITS-1:2] WA_ONE = 1;

   logic [ICCM_CW_W-1:0] cw_lo, cw_hi;
   logic [31:0]          d_lo, d_hi;
   logic                 sb_lo, sb_hi, db_lo, db_hi;
   logic [1:0]           mask;
   logic [ICCM_BITS-1:2] wa_lo, wa_hi;
   logic                 unused_addr_bit;

   iccm_corr_state_t     state_q;
   logic                 hi_pend_q;
   logic [ICCM_CW_W-1:0] hi_cw_q, wr_cw_q;
   logic [ICCM_BITS-1:2] hi_wa_q, wr_wa_q;
   logic                 corr_req_q;

   el2_ifu_iccm_secded_dec u_dec_lo (
      .cw_i(iccm_rd_data_ecc[ICCM_CW_W-1:0]), .cw_corr_o(cw_lo), .data_o(d_lo), .sb_o(sb_lo), .db_o(db_lo)
   );
   el2_ifu_iccm_secded_dec u_dec_hi (
      .cw_i(iccm_rd_data_ecc[77:ICCM_CW_W]), .cw_corr_o(cw_hi), .data_o(d_hi), .sb_o(sb_hi), .db_o(db_hi)
   );

   assign sb_err       = {sb_hi, sb_lo} & {2{rd_vld}};
   assign db_err       = {db_hi, db_lo} & {2{rd_vld}};
   assign rd_data_corr = rd_vld ? {d_hi, d_lo} : '0;
   assign mask         = sb_err & ~db_err;

   // Word addresses wrap naturally at the top of the ICCM.
   assign wa_lo           = rd_addr_q[ICCM_BITS-1:2];
   assign wa_hi           = wa_lo + WA_ONE;
   assign unused_addr_bit = rd_addr_q[1];

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         hi_pend_q  <= 1'b0;
         hi_cw_q    <= '0;
         hi_wa_q    <= '0;
         wr_cw_q    <= '0;
         wr_wa_q    <= '0;
         corr_req_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|mask) begin
                  hi_pend_q  <= mask[1];
                  hi_cw_q    <= cw_hi;
                  hi_wa_q    <= wa_hi;
                  corr_req_q <= 1'b1;
                  if (mask[0]) begin
                     state_q <= REQ_LO;
                     wr_cw_q <= cw_lo;
                     wr_wa_q <= wa_lo;
                  end else begin
                     state_q <= REQ_HI;
                     wr_cw_q <= cw_hi;
                     wr_wa_q <= wa_hi;
                  end
               end
            end
            REQ_LO: begin
               if (corr_gnt) begin
                  hi_pend_q <= 1'b0;
                  if (hi_pend_q) begin
                     state_q <= REQ_HI;
                     wr_cw_q <= hi_cw_q;
                     wr_wa_q <= hi_wa_q;
                  end else begin
                     state_q    <= IDLE;
                     corr_req_q <= 1'b0;
                  end
               end
            end
            REQ_HI: begin
               if (corr_gnt) begin
                  state_q    <= IDLE;
                  corr_req_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               corr_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign corr_req              = corr_req_q;
   assign corr_wr_addr          = {wr_wa_q, 1'b0};
   assign corr_wr_data          = {wr_cw_q, wr_cw_q};
   assign corr_wr_size          = ICCM_CORR_WR_SIZE;
   assign iccm_buf_correct_ecc  = corr_req_q & corr_gnt;
   assign iccm_correction_state = (state_q != IDLE);

`ifdef ICCM_ECC_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] sb_cnt_q, db_cnt_q;

   function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] c, input logic [1:0] e);
      logic [ERR_CNT_W:0] s;
      s = {1'b0, c} + (ERR_CNT_W+1)'(e[0]) + (ERR_CNT_W+1)'(e[1]);
      return s[ERR_CNT_W] ? '1 : s[ERR_CNT_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         sb_cnt_q <= '0;
         db_cnt_q <= '0;
      end else if (cnt_clr) begin
         sb_cnt_q <= '0;
         db_cnt_q <= '0;
      end else begin
         sb_cnt_q <= sat_add(sb_cnt_q, sb_err);
         db_cnt_q <= sat_add(db_cnt_q, db_err);
      end
   end

   assign sb_cnt = sb_cnt_q;
   assign db_cnt = db_cnt_q;
`endif

endmodule
